aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL have parameter ROUND_LAT, default 1, giving the cycles per round of the attached round datapath (legal 1..8).
REQ-002 The block SHALL have parameter NUM_ROUNDS, default 10, giving the total AES rounds after the initial key add (legal 10, 12, 14).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port key_ready, input, 1 bit: the expanded round keys are valid.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a plaintext block is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the controller can accept a block.
REQ-008 The block SHALL have port state_load, output, 1 bit: the datapath state register loads the plaintext.
REQ-009 The block SHALL have port round_en, output, 1 bit: the datapath state register captures the current round result.
REQ-010 The block SHALL have port round_num, output, 4 bits: the current round index; it also serves as the round-key select.
REQ-011 The block SHALL have port sel_init, output, 1 bit: key-add only (round 0).
REQ-012 The block SHALL have port sel_final, output, 1 bit: final round, MixColumns bypassed.
REQ-013 The block SHALL have port out_valid, output, 1 bit: the ciphertext in the state register is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the ciphertext.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, INIT, ROUND, FINAL and DONE.
REQ-017 The block SHALL drive in_ready = 1 only in IDLE and only while key_ready = 1.
REQ-018 The block SHALL drive state_load = in_valid & in_ready, combinationally, in the acceptance cycle; the FSM SHALL then go IDLE->INIT.
REQ-019 INIT SHALL last exactly 1 cycle, with round_num = 0, sel_init = 1 and round_en = 1; the next state SHALL be ROUND with round_num = 1.
REQ-020 ROUND SHALL cover rounds 1..NUM_ROUNDS-1, each lasting ROUND_LAT cycles, tracked by an internal cycle counter cleared at each round start.
REQ-021 round_en SHALL pulse only in the last cycle of each round; round_num SHALL increment on that edge.
REQ-022 The FSM SHALL go ROUND->FINAL when the round with round_num = NUM_ROUNDS-1 completes.
REQ-023 FINAL SHALL have sel_final = 1 and round_num = NUM_ROUNDS, SHALL last ROUND_LAT cycles, and SHALL pulse round_en in its last cycle; the next state SHALL be DONE.
REQ-024 DONE SHALL hold out_valid = 1 with no round_en and no state_load until out_ready = 1; the FSM SHALL then return to IDLE.
REQ-025 out_valid SHALL rise exactly 2 + NUM_ROUNDS*ROUND_LAT cycles after the acceptance cycle.
REQ-026 in_ready SHALL be 0 in DONE, so a back-to-back block is accepted no earlier than the cycle after the out_valid&out_ready handshake.
REQ-027 A fall of key_ready outside IDLE SHALL be ignored; the operation in flight SHALL complete.
REQ-028 Outside their defined states, sel_init, sel_final, round_en and state_load SHALL be 0, and round_num SHALL hold its last value.

Reset
REQ-029 While rst = 1 at a clock edge, the FSM SHALL go to IDLE and round_num and the cycle counter SHALL clear to 0, regardless of state (including mid-round).
REQ-030 After reset, out_valid, round_en, sel_init, sel_final and busy SHALL be 0, and state_load SHALL be 0 while rst is asserted.
REQ-031 There SHALL be no asynchronous reset path.

Configuration
REQ-032 When AES_ROUND_CTRL_ABORT_EN is defined, the block SHALL have an input port abort (1 bit); abort = 1 in any non-IDLE state SHALL force the next state to IDLE, suppress round_en in that cycle, and produce no out_valid for the aborted block.
REQ-033 When AES_ROUND_CTRL_ABORT_EN is undefined, the abort port and its logic SHALL be absent, and operation SHALL be as in REQ-016..028.

Verification
REQ-034 The bench SHALL cover defaults: key_ready = 1, in_valid for 1 cycle at cycle 0, out_ready = 1 -> exactly 11 round_en pulses, round_num sequence 0..10, out_valid at cycle 12 for 1 cycle.
REQ-035 The bench SHALL cover ROUND_LAT = 3: accept at cycle 0 -> round_en at cycles 1, 4, 7, ..., 31, and out_valid at cycle 32.
REQ-036 The bench SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid stays high for 6 cycles, in_ready = 0 throughout, and IDLE is reached on the following edge.
REQ-037 The bench SHALL cover key gating: key_ready = 0 with in_valid = 1 -> in_ready = 0 and no state_load; key_ready rising -> acceptance the same cycle.
REQ-038 The bench SHALL cover reset mid-operation: rst = 1 when round_num = 5 -> next cycle IDLE, round_num = 0, busy = 0, and no out_valid.
REQ-039 The bench SHALL cover abort with AES_ROUND_CTRL_ABORT_EN defined: abort = 1 in round 7 -> IDLE the next cycle, no round_en in the abort cycle, and no out_valid; a new block is then accepted normally.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer driving an external iterative round datapath.
// Ports: clk, rst (sync, active-high); key_ready, in_valid/in_ready accept a block, state_load loads it;
// round_en captures a round result, round_num selects round/key, sel_init/sel_final pick round 0 / last round;
// out_valid/out_ready hand off the ciphertext; busy is high outside IDLE.
// Optional AES_ROUND_CTRL_ABORT_EN adds input abort, which drops the block in flight and returns to IDLE.
module aes_round_ctrl #(
  parameter int ROUND_LAT  = 1,
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ready,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       state_load,
  output logic       round_en,
  output logic [3:0] round_num,
  output logic       sel_init,
  output logic       sel_final,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
  state_t state, next;
  logic [2:0] cnt;
  logic last, kill, timed;
  assign last  = cnt == 3'(ROUND_LAT - 1);
  assign timed = state == ROUND || state == FINAL;
`ifdef AES_ROUND_CTRL_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_num <= 4'd0;
      cnt       <= 3'd0;
    end else begin
      state     <= next;
      cnt       <= (timed && !kill && !last) ? cnt + 3'd1 : 3'd0;
      round_num <= state_load ? 4'd0 : state == INIT ? 4'd1 :
                   (round_en && state == ROUND) ? round_num + 4'd1 : round_num;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = state_load ? INIT : IDLE;
      INIT:    next = ROUND;
      ROUND:   next = (last && round_num == 4'(NUM_ROUNDS - 1)) ? FINAL : ROUND;
      FINAL:   next = last ? DONE : FINAL;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
    if (kill) next = IDLE;
  end
  always_comb begin
    in_ready   = !rst && state == IDLE && key_ready;
    state_load = in_valid && in_ready;
    round_en   = !kill && (state == INIT || (timed && last));
    sel_init   = state == INIT;
    sel_final  = state == FINAL;
    out_valid  = state == DONE;
    busy       = state != IDLE;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed checks of the AES round controller at ROUND_LAT 1 and 3.
module tb_aes_round_ctrl;
  logic clk = 0, rst = 1, key_ready = 1, in_valid = 0, out_ready = 1, abort = 0;
  logic a_in_ready, a_state_load, a_round_en, a_sel_init, a_sel_final, a_out_valid, a_busy;
  logic b_in_ready, b_state_load, b_round_en, b_sel_init, b_sel_final, b_out_valid, b_busy;
  logic [3:0] a_round_num, b_round_num;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  aes_round_ctrl u0 (
    .clk(clk), .rst(rst), .key_ready(key_ready), .in_valid(in_valid), .in_ready(a_in_ready),
    .state_load(a_state_load), .round_en(a_round_en), .round_num(a_round_num), .sel_init(a_sel_init),
    .sel_final(a_sel_final), .out_valid(a_out_valid), .out_ready(out_ready),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(a_busy));

  aes_round_ctrl #(.ROUND_LAT(3)) u3 (
    .clk(clk), .rst(rst), .key_ready(key_ready), .in_valid(in_valid), .in_ready(b_in_ready),
    .state_load(b_state_load), .round_en(b_round_en), .round_num(b_round_num), .sel_init(b_sel_init),
    .sel_final(b_sel_final), .out_valid(b_out_valid), .out_ready(out_ready),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(b_busy));

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic start;
    rst = 1; in_valid = 0; key_ready = 1; out_ready = 1; abort = 0;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; key_ready = 1; in_valid = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_state_load !== 1'b0) begin n_bad++; $display("FAIL reset_state_load: got %b expected 0", a_state_load); end
    n_cmp++; if ({a_busy, a_out_valid, a_round_en, a_sel_init, a_sel_final} !== 5'b0) begin n_bad++; $display("FAIL reset_outputs: got %b expected 00000", {a_busy, a_out_valid, a_round_en, a_sel_init, a_sel_final}); end
    n_cmp++; if (a_round_num !== 4'd0) begin n_bad++; $display("FAIL reset_round_num: got %0d expected 0", a_round_num); end
    n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_lat3: got %b expected 0", b_busy); end
    next_cycle();
    in_valid = 0; rst = 0;
  endtask

  task automatic test_default;
    int en = 0;
    start();
    for (int c = 0; c <= 14; c++) begin
      in_valid = c == 0;
      @(negedge clk);
      if (c == 0) begin n_cmp++; if (a_state_load !== 1'b1) begin n_bad++; $display("FAIL def_load: got %b expected 1", a_state_load); end end
      n_cmp++; if (a_round_en !== (c >= 1 && c <= 11)) begin n_bad++; $display("FAIL def_round_en c=%0d: got %b expected %b", c, a_round_en, c >= 1 && c <= 11); end
      if (a_round_en) begin
        n_cmp++; if (a_round_num !== 4'(en)) begin n_bad++; $display("FAIL def_round_num c=%0d: got %0d expected %0d", c, a_round_num, en); end
        en++;
      end
      n_cmp++; if (a_sel_init !== (c == 1) || a_sel_final !== (c == 11)) begin n_bad++; $display("FAIL def_sel c=%0d: got %b%b expected %b%b", c, a_sel_init, a_sel_final, c == 1, c == 11); end
      n_cmp++; if (a_out_valid !== (c == 12)) begin n_bad++; $display("FAIL def_out_valid c=%0d: got %b expected %b", c, a_out_valid, c == 12); end
      n_cmp++; if (a_busy !== (c >= 1 && c <= 12)) begin n_bad++; $display("FAIL def_busy c=%0d: got %b expected %b", c, a_busy, c >= 1 && c <= 12); end
      next_cycle();
    end
    n_cmp++; if (en != 11) begin n_bad++; $display("FAIL def_en_count: got %0d expected 11", en); end
  endtask

  task automatic test_lat3;
    int en = 0;
    logic exp_en;
    start();
    for (int c = 0; c <= 34; c++) begin
      in_valid = c == 0;
      exp_en = c >= 1 && c <= 31 && (c - 1) % 3 == 0;
      @(negedge clk);
      n_cmp++; if (b_round_en !== exp_en) begin n_bad++; $display("FAIL lat3_round_en c=%0d: got %b expected %b", c, b_round_en, exp_en); end
      if (b_round_en) begin
        n_cmp++; if (b_round_num !== 4'((c - 1) / 3)) begin n_bad++; $display("FAIL lat3_round_num c=%0d: got %0d expected %0d", c, b_round_num, (c - 1) / 3); end
        en++;
      end
      n_cmp++; if (b_out_valid !== (c == 32)) begin n_bad++; $display("FAIL lat3_out_valid c=%0d: got %b expected %b", c, b_out_valid, c == 32); end
      next_cycle();
    end
    n_cmp++; if (en != 11) begin n_bad++; $display("FAIL lat3_en_count: got %0d expected 11", en); end
  endtask

  task automatic test_backpressure;
    start();
    for (int c = 0; c <= 19; c++) begin
      in_valid = c == 0;
      out_ready = c >= 17;
      @(negedge clk);
      n_cmp++; if (a_out_valid !== (c >= 12 && c <= 17)) begin n_bad++; $display("FAIL bp_out_valid c=%0d: got %b expected %b", c, a_out_valid, c >= 12 && c <= 17); end
      if (c >= 12 && c <= 17) begin n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, a_in_ready); end end
      if (c == 18) begin n_cmp++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle: got busy=%b in_ready=%b expected 0 1", a_busy, a_in_ready); end end
      next_cycle();
    end
  endtask

  task automatic test_key_gating;
    start();
    key_ready = 0; in_valid = 1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (a_in_ready !== 1'b0 || a_state_load !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL key_gate c=%0d: got %b%b%b expected 000", c, a_in_ready, a_state_load, a_busy); end
      next_cycle();
    end
    key_ready = 1;
    @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1 || a_state_load !== 1'b1) begin n_bad++; $display("FAIL key_rise_accept: got %b%b expected 11", a_in_ready, a_state_load); end
    next_cycle();
    in_valid = 0; key_ready = 0;
    for (int c = 4; c <= 16; c++) begin
      @(negedge clk);
      if (c == 4) begin n_cmp++; if (a_sel_init !== 1'b1) begin n_bad++; $display("FAIL key_init: got %b expected 1", a_sel_init); end end
      n_cmp++; if (a_out_valid !== (c == 15)) begin n_bad++; $display("FAIL key_drop_out_valid c=%0d: got %b expected %b", c, a_out_valid, c == 15); end
      next_cycle();
    end
    key_ready = 1;
  endtask

  task automatic test_reset_mid;
    int ov = 0;
    start();
    for (int c = 0; c <= 6; c++) begin
      in_valid = c == 0;
      rst = c == 6;
      @(negedge clk);
      if (c == 6) begin n_cmp++; if (a_round_num !== 4'd5) begin n_bad++; $display("FAIL rm_round_num_before: got %0d expected 5", a_round_num); end end
      next_cycle();
    end
    rst = 0;
    @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0 || a_round_num !== 4'd0 || a_round_en !== 1'b0) begin n_bad++; $display("FAIL rm_after: got busy=%b round_num=%0d round_en=%b expected 0 0 0", a_busy, a_round_num, a_round_en); end
    for (int c = 7; c <= 20; c++) begin
      @(negedge clk);
      ov += int'(a_out_valid);
      next_cycle();
    end
    n_cmp++; if (ov != 0) begin n_bad++; $display("FAIL rm_no_out_valid: got %0d expected 0", ov); end
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort;
    int ov = 0;
    start();
    for (int c = 0; c <= 8; c++) begin
      in_valid = c == 0;
      abort = c == 8;
      @(negedge clk);
      if (c == 8) begin n_cmp++; if (a_round_num !== 4'd7 || a_round_en !== 1'b0) begin n_bad++; $display("FAIL ab_cycle: got round_num=%0d round_en=%b expected 7 0", a_round_num, a_round_en); end end
      next_cycle();
    end
    abort = 0;
    for (int c = 9; c <= 20; c++) begin
      @(negedge clk);
      if (c == 9) begin n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL ab_idle: got %b expected 0", a_busy); end end
      ov += int'(a_out_valid);
      next_cycle();
    end
    n_cmp++; if (ov != 0) begin n_bad++; $display("FAIL ab_no_out_valid: got %0d expected 0", ov); end
    for (int c = 0; c <= 13; c++) begin
      in_valid = c == 0;
      @(negedge clk);
      if (c == 0) begin n_cmp++; if (a_state_load !== 1'b1) begin n_bad++; $display("FAIL ab_reaccept: got %b expected 1", a_state_load); end end
      n_cmp++; if (a_out_valid !== (c == 12)) begin n_bad++; $display("FAIL ab_new_out_valid c=%0d: got %b expected %b", c, a_out_valid, c == 12); end
      next_cycle();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_lat3();
    test_backpressure();
    test_key_gating();
    test_reset_mid();
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
